// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: steps through fetch, execute, memory and writeback.
// It computes the next PC and strobes the PC and register file at retirement.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_we,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        dmem_op,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] target,
    input  logic        halt,
    output logic        rf_we,
    output logic [31:0] instret,
    output logic        misalign,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5,
        TRAP   = 3'd6
    } state_t;

    state_t      cur_state;
    state_t      next_state;
    logic        reset_q;
    logic [31:0] candidate;
    logic        aligned;

    assign state = cur_state;

    always_comb begin
        if (is_jalr) begin
            candidate = {target[31:1], 1'b0};
        end else if (is_jal || (is_branch && branch_taken)) begin
            candidate = target;
        end else begin
            candidate = pc_cur + 32'd4;
        end
        aligned = (candidate[1:0] == 2'b00);
    end

    // reset_q keeps INIT silent for the cycle right after a reset edge, so the
    // RESET_PC load strobe only appears once reset has been released.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= INIT;
            reset_q   <= 1'b1;
            instret   <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            reset_q   <= 1'b0;
            cur_state <= next_state;
            if (cur_state == WB) begin
                if (aligned) begin
                    instret <= instret + 32'd1;
                end else begin
                    misalign <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        pc_next    = pc_cur;
        pc_we      = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        rf_we      = 1'b0;
        case (cur_state)
            INIT: begin
                if (!reset_q) begin
                    pc_we      = 1'b1;
                    pc_next    = RESET_PC;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = dmem_op ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    next_state = WB;
                end
            end
            WB: begin
                // A misaligned target traps even when halt is also requested.
                if (aligned) begin
                    pc_we      = 1'b1;
                    rf_we      = 1'b1;
                    pc_next    = candidate;
                    next_state = halt ? HALTED : FETCH;
                end else begin
                    next_state = TRAP;
                end
            end
            HALTED: next_state = HALTED;
            TRAP:   next_state = TRAP;
            default: next_state = INIT;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: drives whole instructions and checks each
// cycle against a transaction-level model of PC, retire count and trap behaviour.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_cur = 32'd0;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        dmem_op = 1'b0;
    logic        dmem_req;
    logic        dmem_ack = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] target = 32'd0;
    logic        halt = 1'b0;
    logic        rf_we;
    logic [31:0] instret;
    logic        misalign;
    logic [2:0]  state;

    int          check_count = 0;
    int          pass_count = 0;
    logic [31:0] model_pc = 32'd0;
    logic [31:0] model_instret = 32'd0;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next), .pc_we(pc_we),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_op(dmem_op), .dmem_req(dmem_req),
        .dmem_ack(dmem_ack), .is_branch(is_branch), .branch_taken(branch_taken),
        .is_jal(is_jal), .is_jalr(is_jalr), .target(target), .halt(halt), .rf_we(rf_we),
        .instret(instret), .misalign(misalign), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Architectural next-PC rule: JALR clears bit 0, JAL/taken branch jump, else fall through.
    function automatic logic [31:0] refNextPc(input logic [31:0] pc, input bit br, input bit tk,
                                              input bit jal, input bit jalr, input logic [31:0] tgt);
        if (jalr) return tgt & 32'hFFFF_FFFE;
        if (jal || (br && tk)) return tgt;
        return pc + 32'd4;
    endfunction

    task automatic driveNoise();
        is_branch    = 1'($urandom);
        branch_taken = 1'($urandom);
        is_jal       = 1'($urandom);
        is_jalr      = 1'($urandom);
        halt         = 1'($urandom);
        dmem_op      = 1'($urandom);
        target       = $urandom;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_pc_we"}, pc_we, 0);
        checkOutput({tag, "_rf_we"}, rf_we, 0);
        checkOutput({tag, "_imem_req"}, imem_req, 0);
        checkOutput({tag, "_dmem_req"}, dmem_req, 0);
    endtask

    // Called just after reset has been raised ahead of a rising edge.
    task automatic resetTail();
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        driveNoise();
        pc_cur = $urandom;
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_instret", instret, 0);
        checkOutput("rst_misalign", misalign, 0);
        checkQuiet("rst");
        @(negedge clk);
        driveNoise();
        #1;
        checkOutput("init_state", state, 0);
        checkOutput("init_pc_we", pc_we, 1);
        checkOutput("init_pc_next", pc_next, RST_PC);
        checkOutput("init_rf_we", rf_we, 0);
        model_pc = RST_PC;
        model_instret = 32'd0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        halt = 1'b1;
        resetTail();
    endtask

    task automatic absorbCheck(input logic [2:0] exp_state, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            driveNoise();
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            pc_cur = $urandom;
            #1;
            checkOutput("abs_state", state, exp_state);
            checkOutput("abs_misalign", misalign, (exp_state == 3'd6) ? 1 : 0);
            checkOutput("abs_instret", instret, model_instret);
            checkOutput("abs_pc_next", pc_next, pc_cur);
            checkQuiet("abs");
        end
    endtask

    // One full instruction; result: 0 continue, 1 halted, 2 trapped, 3 reset mid-flight.
    task automatic applyStimulus(input int waits, input bit dop, input int mlat,
                                 input bit br, input bit tk, input bit jal, input bit jalr,
                                 input logic [31:0] tgt, input bit hlt, input int abort_at,
                                 output int result);
        logic [31:0] cand;
        result = 0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            driveNoise();
            pc_cur = model_pc;
            imem_ack = (i == waits);
            dmem_ack = 1'($urandom);
            #1;
            checkOutput("fetch_state", state, 1);
            checkOutput("fetch_imem_req", imem_req, 1);
            checkOutput("fetch_pc_we", pc_we, 0);
            checkOutput("fetch_pc_next", pc_next, model_pc);
            checkOutput("fetch_instret", instret, model_instret);
            if (abort_at == 1) begin
                reset = 1'b1;
                imem_ack = 1'b1;
                resetTail();
                result = 3;
                return;
            end
        end
        @(negedge clk);
        driveNoise();
        dmem_op = dop;
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        #1;
        checkOutput("exec_state", state, 2);
        checkQuiet("exec");
        if (dop) begin
            for (int i = 0; i < mlat; i++) begin
                @(negedge clk);
                driveNoise();
                imem_ack = 1'($urandom);
                dmem_ack = (i == mlat - 1);
                #1;
                checkOutput("mem_state", state, 3);
                checkOutput("mem_dmem_req", dmem_req, 1);
                checkOutput("mem_pc_we", pc_we, 0);
                if (abort_at == 2) begin
                    reset = 1'b1;
                    dmem_ack = 1'b1;
                    resetTail();
                    result = 3;
                    return;
                end
            end
        end
        @(negedge clk);
        driveNoise();
        is_branch = br;
        branch_taken = tk;
        is_jal = jal;
        is_jalr = jalr;
        target = tgt;
        halt = hlt;
        pc_cur = model_pc;
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        #1;
        cand = refNextPc(model_pc, br, tk, jal, jalr, tgt);
        checkOutput("wb_state", state, 4);
        checkOutput("wb_dmem_req", dmem_req, 0);
        if (cand % 4 == 0) begin
            checkOutput("wb_pc_we", pc_we, 1);
            checkOutput("wb_rf_we", rf_we, 1);
            checkOutput("wb_pc_next", pc_next, cand);
            model_instret = model_instret + 32'd1;
            model_pc = cand;
            result = hlt ? 1 : 0;
        end else begin
            checkOutput("wb_trap_pc_we", pc_we, 0);
            checkOutput("wb_trap_rf_we", rf_we, 0);
            checkOutput("wb_trap_pc_next", pc_next, model_pc);
            result = 2;
        end
    endtask

    task automatic finishInstr(input int result);
        if (result == 1) begin
            absorbCheck(3'd5, 3);
            doReset();
        end else if (result == 2) begin
            absorbCheck(3'd6, 3);
            doReset();
        end
    endtask

    initial begin
        int res;
        doReset();

        // Sequential ALU op at 0x10 with two fetch wait states.
        model_pc = 32'h10;
        applyStimulus(2, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, res);
        checkOutput("seq_pc", model_pc, 32'h14);
        // Load with three-cycle data latency.
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 32'h0, 0, 0, res);
        applyStimulus(1, 0, 1, 1, 1, 0, 0, 32'h40, 0, 0, res);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 32'h80, 0, 0, res);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 32'h81, 0, 0, res);
        // Fall-through wraps past the top of the address space.
        model_pc = 32'hFFFF_FFFC;
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, res);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h0, 1, 0, res);
        finishInstr(res);
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 32'h102, 1, 0, res);
        finishInstr(res);
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 32'h0, 0, 2, res);

        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [31:0] tgt;
            int          abort_at;
            kind = $urandom_range(0, 4);
            tgt = ($urandom_range(0, 9) < 8) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
            applyStimulus($urandom_range(0, 3), 1'($urandom), $urandom_range(1, 4),
                          (kind == 1) || (kind == 2), kind == 1, kind == 3, kind == 4,
                          tgt, $urandom_range(0, 15) == 0, abort_at, res);
            finishInstr(res);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
